// File: rtl/issue_pkg.sv
// Shared types for the issue controller: FSM state, memory-access codes and
// the architectural register index.
package issue_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Memory-access codes, matching the decoder's encoding.
  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode / execute / writeback signal bundle around the issue controller.
// The master side is the surrounding pipeline, the slave side is issue_ctrl.
interface issue_ctrl_if;
  import issue_pkg::*;

  logic       dec_valid;
  logic       dec_ready;
  reg_idx_t   dec_rs1;
  reg_idx_t   dec_rs2;
  reg_idx_t   dec_rd;
  logic       dec_use_rs1;
  logic       dec_use_rs2;
  logic       dec_reg_write;
  logic [1:0] dec_mem_access;
  logic       dec_ctrl_xfer;

  logic       ex_valid;
  logic       ex_ready;
  reg_idx_t   ex_rd;
  logic       ex_reg_write;
  logic [1:0] ex_mem_access;

  logic       wb_valid;
  reg_idx_t   wb_rd;
  logic       mem_done;
  logic       br_resolve;
  logic       flush;
  logic       err_underflow;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2,
           dec_reg_write, dec_mem_access, dec_ctrl_xfer,
           ex_ready, wb_valid, wb_rd, mem_done, br_resolve, flush,
    input  dec_ready, ex_valid, ex_rd, ex_reg_write, ex_mem_access, err_underflow
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2,
           dec_reg_write, dec_mem_access, dec_ctrl_xfer,
           ex_ready, wb_valid, wb_rd, mem_done, br_resolve, flush,
    output dec_ready, ex_valid, ex_rd, ex_reg_write, ex_mem_access, err_underflow
  );

endinterface

// File: rtl/issue_scoreboard.sv
// Per-register pending-write counters with two combinational lookup ports.
// x0 is never tracked; a writeback to an idle register raises an underflow strobe.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     inc_en,
  input  reg_idx_t inc_rd,
  input  logic     dec_en,
  input  reg_idx_t dec_rd,
  input  reg_idx_t lk1_rd,
  input  reg_idx_t lk2_rd,
  output logic     lk1_busy,
  output logic     lk2_busy,
  output logic     dec_ok,
  output logic     underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pending [32];
  logic             inc_live;
  logic             dec_live;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign inc_live  = inc_en && (inc_rd != '0);
  assign dec_live  = dec_en && (dec_rd != '0);
  assign dec_ok    = dec_live && (pending[dec_rd] != '0);
  assign underflow = dec_live && (pending[dec_rd] == '0);
  assign lk1_busy  = (pending[lk1_rd] != '0);
  assign lk2_busy  = (pending[lk2_rd] != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) pending[i] <= '0;
    end else begin
      // A simultaneous increment and decrement on one register cancel out.
      for (int i = 1; i < 32; i++) begin
        case ({inc_live && (inc_rd == reg_idx_t'(i)), dec_ok && (dec_rd == reg_idx_t'(i))})
          2'b10:   pending[i] <= sat_inc(pending[i]);
          2'b01:   pending[i] <= pending[i] - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: one-entry issue register, RAW scoreboard, branch and
// memory-port stalls, flush drain. Define ISSUE_STATS_EN to add handoff/stall counters.
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input logic         clk,
  input logic         reset,
  issue_ctrl_if.slave bus
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_stall
`endif
);

  state_t           state;
  logic             mem_busy;
  logic [CNT_W-1:0] inflight;
  logic             ex_ctrl_xfer;

  logic busy_rs1, busy_rs2;
  logic sb_dec_ok, sb_underflow;
  logic hazard, mem_conflict;
  logic accept, handoff, inc_cnt;

  function automatic logic src_hazard(input logic use_src, input reg_idx_t src,
                                      input logic busy, input logic held_valid,
                                      input logic held_write, input reg_idx_t held_rd);
    return use_src && (src != '0) &&
           (busy || (held_valid && held_write && (held_rd == src)));
  endfunction

  // The held instruction is not in the scoreboard yet, so it is checked directly.
  assign hazard = src_hazard(bus.dec_use_rs1, bus.dec_rs1, busy_rs1,
                             bus.ex_valid, bus.ex_reg_write, bus.ex_rd) ||
                  src_hazard(bus.dec_use_rs2, bus.dec_rs2, busy_rs2,
                             bus.ex_valid, bus.ex_reg_write, bus.ex_rd);

  assign mem_conflict = (bus.dec_mem_access != MEM_NONE) &&
                        (mem_busy || (bus.ex_valid && (bus.ex_mem_access != MEM_NONE)));

  assign bus.dec_ready = reset && (state == RUN) && !hazard && !bus.flush &&
                         (!bus.ex_valid || bus.ex_ready) &&
                         (inflight < CNT_W'(MAX_INFLIGHT)) && !mem_conflict;

  assign accept  = bus.dec_valid && bus.dec_ready;
  assign handoff = bus.ex_valid && bus.ex_ready && !bus.flush;
  assign inc_cnt = handoff && bus.ex_reg_write && (bus.ex_rd != '0);

  issue_scoreboard #(.CNT_W(CNT_W)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .inc_en    (handoff && bus.ex_reg_write),
    .inc_rd    (bus.ex_rd),
    .dec_en    (bus.wb_valid),
    .dec_rd    (bus.wb_rd),
    .lk1_rd    (bus.dec_rs1),
    .lk2_rd    (bus.dec_rs2),
    .lk1_busy  (busy_rs1),
    .lk2_busy  (busy_rs2),
    .dec_ok    (sb_dec_ok),
    .underflow (sb_underflow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= RUN;
      mem_busy          <= 1'b0;
      inflight          <= '0;
      ex_ctrl_xfer      <= 1'b0;
      bus.ex_valid      <= 1'b0;
      bus.ex_rd         <= '0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_access <= MEM_NONE;
      bus.err_underflow <= 1'b0;
    end else begin
      case ({inc_cnt, sb_dec_ok})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: ;
      endcase

      if (handoff && (bus.ex_mem_access != MEM_NONE)) mem_busy <= 1'b1;
      else if (bus.mem_done)                          mem_busy <= 1'b0;

      if (sb_underflow) bus.err_underflow <= 1'b1;

      if (bus.flush)    bus.ex_valid <= 1'b0;
      else if (accept)  bus.ex_valid <= 1'b1;
      else if (handoff) bus.ex_valid <= 1'b0;

      if (accept) begin
        bus.ex_rd         <= bus.dec_rd;
        bus.ex_reg_write  <= bus.dec_reg_write;
        bus.ex_mem_access <= bus.dec_mem_access;
        ex_ctrl_xfer      <= bus.dec_ctrl_xfer;
      end

      // Flush overrides every other transition, including a branch resolve.
      if (bus.flush) begin
        state <= DRAIN;
      end else begin
        case (state)
          RUN, BR_WAIT: begin
            if (handoff && ex_ctrl_xfer)              state <= BR_WAIT;
            else if (state == BR_WAIT && bus.br_resolve) state <= RUN;
          end
          DRAIN:   if (!mem_busy) state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (handoff)                          stat_issued <= stat_issued + 32'd1;
      if (bus.dec_valid && !bus.dec_ready)  stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed hazard/full/branch/flush/underflow sequences, then
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_issue_ctrl;
  import issue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issue_ctrl_if bus ();

`ifdef ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_stall;
  int          m_issued, m_stall;
`endif

  issue_ctrl #(.MAX_INFLIGHT(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ISSUE_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  // Reference model state
  int pend [32];
  int infl;
  bit mbusy, m_brwait, m_drain, m_err;
  bit m_exv, m_exrw, m_exctrl;
  int m_exrd, m_exmem;

  int n_vec, n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    infl = 0; mbusy = 0; m_brwait = 0; m_drain = 0; m_err = 0;
    m_exv = 0; m_exrw = 0; m_exctrl = 0; m_exrd = 0; m_exmem = 0;
`ifdef ISSUE_STATS_EN
    m_issued = 0; m_stall = 0;
`endif
  endtask

  function automatic bit src_blocked(input bit used, input int s);
    return used && (s != 0) && ((pend[s] > 0) || (m_exv && m_exrw && (m_exrd == s)));
  endfunction

  function automatic bit exp_ready();
    bit haz, memc;
    haz  = src_blocked(bus.dec_use_rs1, int'(bus.dec_rs1)) ||
           src_blocked(bus.dec_use_rs2, int'(bus.dec_rs2));
    memc = (bus.dec_mem_access != 2'd0) && (mbusy || (m_exv && (m_exmem != 0)));
    return reset && !m_brwait && !m_drain && !haz && !bus.flush &&
           (!m_exv || bus.ex_ready) && (infl < 4) && !memc;
  endfunction

  // Advance the model across one clock edge using the inputs held during the cycle.
  task automatic model_edge();
    bit rdy, acc, ho, wb_ok, old_mbusy;
    int w;
    rdy = exp_ready();
    acc = bus.dec_valid && rdy;
    ho  = m_exv && bus.ex_ready && !bus.flush;
    wb_ok = 0;
    old_mbusy = mbusy;
    w = int'(bus.wb_rd);
`ifdef ISSUE_STATS_EN
    if (bus.dec_valid && !rdy) m_stall++;
    if (ho) m_issued++;
`endif
    if (bus.wb_valid && w != 0) begin
      if (pend[w] > 0) wb_ok = 1;
      else m_err = 1;
    end
    if (wb_ok) begin pend[w]--; infl--; end
    if (ho && m_exrw && m_exrd != 0) begin
      if (pend[m_exrd] < 7) pend[m_exrd]++;
      infl++;
    end
    if (ho && m_exmem != 0) mbusy = 1;
    else if (bus.mem_done)  mbusy = 0;
    if (bus.flush) begin
      m_drain = 1; m_brwait = 0;
    end else if (m_drain) begin
      if (!old_mbusy) m_drain = 0;
    end else if (ho && m_exctrl) begin
      m_brwait = 1;
    end else if (m_brwait && bus.br_resolve) begin
      m_brwait = 0;
    end
    if (bus.flush) m_exv = 0;
    else if (acc) begin
      m_exv = 1; m_exrd = int'(bus.dec_rd); m_exrw = bus.dec_reg_write;
      m_exmem = int'(bus.dec_mem_access); m_exctrl = bus.dec_ctrl_xfer;
    end else if (ho) m_exv = 0;
  endtask

  task automatic check_outputs();
    chk("dec_ready",     32'(bus.dec_ready),     32'(exp_ready()));
    chk("ex_valid",      32'(bus.ex_valid),      32'(m_exv));
    chk("ex_rd",         32'(bus.ex_rd),         32'(m_exrd));
    chk("ex_reg_write",  32'(bus.ex_reg_write),  32'(m_exrw));
    chk("ex_mem_access", 32'(bus.ex_mem_access), 32'(m_exmem));
    chk("err_underflow", 32'(bus.err_underflow), 32'(m_err));
`ifdef ISSUE_STATS_EN
    chk("stat_issued", stat_issued, 32'(m_issued));
    chk("stat_stall",  stat_stall,  32'(m_stall));
`endif
  endtask

  // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic tick();
    #3;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ex_valid"},  32'(bus.ex_valid),      32'd0);
    chk({tag, "_ex_rd"},     32'(bus.ex_rd),         32'd0);
    chk({tag, "_ex_rw"},     32'(bus.ex_reg_write),  32'd0);
    chk({tag, "_ex_mem"},    32'(bus.ex_mem_access), 32'(MEM_NONE));
    chk({tag, "_err"},       32'(bus.err_underflow), 32'd0);
    chk({tag, "_dec_ready"}, 32'(bus.dec_ready),     32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #2;
    chk_reset_vals(tag);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive_idle();
    bus.dec_valid = 0; bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
    bus.dec_use_rs1 = 0; bus.dec_use_rs2 = 0; bus.dec_reg_write = 0;
    bus.dec_mem_access = MEM_NONE; bus.dec_ctrl_xfer = 0;
    bus.ex_ready = 1; bus.wb_valid = 0; bus.wb_rd = '0;
    bus.mem_done = 0; bus.br_resolve = 0; bus.flush = 0;
  endtask

  task automatic set_dec(input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit rw, input int mem, input bit ctrl);
    bus.dec_valid = 1; bus.dec_rs1 = 5'(rs1); bus.dec_use_rs1 = u1;
    bus.dec_rs2 = 5'(rs2); bus.dec_use_rs2 = u2; bus.dec_rd = 5'(rd);
    bus.dec_reg_write = rw; bus.dec_mem_access = 2'(mem); bus.dec_ctrl_xfer = ctrl;
  endtask

  task automatic writeback(input int rd);
    bus.wb_valid = 1; bus.wb_rd = 5'(rd);
    tick();
    bus.wb_valid = 0;
  endtask

  initial begin
    int cand[$];
    n_vec = 0; n_bad = 0;
    reset = 1'b0;
    drive_idle();
    model_reset();
    #12;
    chk_reset_vals("rst_init");
    @(posedge clk); #1;
    reset = 1'b1;

    // Hazard: add x5,x1,x2 then add x6,x5,x3
    set_dec(1, 1, 2, 1, 5, 1, 0, 0); tick();
    set_dec(5, 1, 3, 1, 6, 1, 0, 0); #1 chk("tp1_raw_ex", 32'(bus.dec_ready), 32'd0);
    tick(); tick(); tick();
    bus.wb_valid = 1; bus.wb_rd = 5'd5; #1 chk("tp1_raw_wb", 32'(bus.dec_ready), 32'd0);
    tick();
    bus.wb_valid = 0; #1 chk("tp1_release", 32'(bus.dec_ready), 32'd1);
    tick();
    drive_idle(); tick(); tick();
    writeback(6);

    // Full: four writers x1..x4 in flight, the fifth waits for a writeback
    for (int r = 1; r <= 4; r++) begin set_dec(0, 0, 0, 0, r, 1, 0, 0); tick(); end
    drive_idle(); tick();
    set_dec(0, 0, 0, 0, 11, 1, 0, 0); #1 chk("tp2_full", 32'(bus.dec_ready), 32'd0);
    tick(); tick();
    bus.wb_valid = 1; bus.wb_rd = 5'd1; tick();
    bus.wb_valid = 0; #1 chk("tp2_release", 32'(bus.dec_ready), 32'd1);
    tick();
    drive_idle(); tick();
    writeback(2); writeback(3); writeback(4); writeback(11);

    // Same-cycle handoff and writeback on x7
    set_dec(0, 0, 0, 0, 7, 1, 0, 0); tick();
    drive_idle(); tick();
    set_dec(0, 0, 0, 0, 7, 1, 0, 0); tick();
    drive_idle(); bus.wb_valid = 1; bus.wb_rd = 5'd7; tick();
    bus.wb_valid = 0;
    set_dec(7, 1, 0, 0, 8, 1, 0, 0); #1 chk("tp3_still_pending", 32'(bus.dec_ready), 32'd0);
    tick();
    bus.dec_valid = 0; writeback(7);
    set_dec(7, 1, 0, 0, 8, 0, 0, 0); #1 chk("tp3_cleared", 32'(bus.dec_ready), 32'd1);
    tick();
    drive_idle(); tick();

    // Control transfer blocks issue until resolved
    set_dec(1, 1, 2, 1, 0, 0, 0, 1); tick();
    drive_idle(); tick();
    set_dec(0, 0, 0, 0, 12, 0, 0, 0); #1 chk("tp4_br_wait", 32'(bus.dec_ready), 32'd0);
    tick(); tick();
    bus.br_resolve = 1; tick();
    bus.br_resolve = 0; #1 chk("tp4_resumed", 32'(bus.dec_ready), 32'd1);
    tick();
    drive_idle(); tick();

    // Flush with a busy memory port
    set_dec(1, 1, 0, 0, 0, 0, 1, 0); tick();
    drive_idle(); tick();
    bus.ex_ready = 0;
    set_dec(0, 0, 0, 0, 13, 1, 0, 0); tick();
    drive_idle(); bus.ex_ready = 0; bus.flush = 1; tick();
    bus.flush = 0; #1 chk("tp5_ex_cleared", 32'(bus.ex_valid), 32'd0);
    set_dec(0, 0, 0, 0, 14, 0, 0, 0);
    tick(); tick(); tick();
    bus.mem_done = 1; tick();
    bus.mem_done = 0; tick(); tick();
    drive_idle(); tick();

    // Underflow is sticky; asynchronous reset clears everything
    writeback(9);
    #1 chk("tp6_underflow", 32'(bus.err_underflow), 32'd1);
    tick(); tick();
    set_dec(0, 0, 0, 0, 15, 1, 2, 0); tick();
    drive_idle(); tick();
    pulse_reset("rst_mid");
    tick(); tick();

    // Randomized traffic with periodic mid-stream resets
    for (int c = 0; c < 3000; c++) begin
      bus.dec_valid      = ($urandom_range(0, 3) != 0);
      bus.dec_rs1        = 5'($urandom_range(0, 7));
      bus.dec_rs2        = 5'($urandom_range(0, 7));
      bus.dec_rd         = 5'($urandom_range(0, 7));
      bus.dec_use_rs1    = $urandom_range(0, 1) == 1;
      bus.dec_use_rs2    = $urandom_range(0, 1) == 1;
      bus.dec_reg_write  = ($urandom_range(0, 3) != 0);
      bus.dec_mem_access = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 2)) : MEM_NONE;
      bus.dec_ctrl_xfer  = ($urandom_range(0, 7) == 0);
      bus.ex_ready       = ($urandom_range(0, 3) != 0);
      bus.mem_done       = ($urandom_range(0, 2) == 0);
      bus.br_resolve     = ($urandom_range(0, 3) == 0);
      bus.flush          = ($urandom_range(0, 39) == 0);
      cand.delete();
      for (int r = 1; r < 32; r++) if (pend[r] > 0) cand.push_back(r);
      if ($urandom_range(0, 199) == 0) begin
        bus.wb_valid = 1; bus.wb_rd = 5'($urandom_range(1, 31));
      end else if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        bus.wb_valid = 1; bus.wb_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end else begin
        bus.wb_valid = ($urandom_range(0, 9) == 0); bus.wb_rd = '0;
      end
      if (c % 600 == 599) pulse_reset("rst_rand");
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
